pi_permute_engine: RTL and testbench

- Multi-round, lane-parametrised successor to the single-bit 5x5 pi-permutation datapath.
- Holds a 25-lane state (each lane W bits) in one register.
- After a start handshake, applies the forward or inverse pi lane permutation a programmable number of times, one round per clock, then pulses done.
- Sits between the state-input mux and downstream round logic of the permutation core.

---
 rtl/pi_permute_engine.sv | 90 +++++++++
 tb/tb_pi_permute_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pi_permute_engine.sv
// Multi-round pi lane permutation engine: 25 lanes of W bits, forward or inverse map,
// one round per clock, with a one-cycle done pulse when the result is ready.
module pi_permute_engine #(
    parameter int W     = 1,
    parameter int CNT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               inv_i,
    input  logic [CNT_W-1:0]   rounds_i,
    input  logic [25*W-1:0]    din_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [25*W-1:0]    dout_o
);

    // state  | meaning
    // IDLE   | waiting for start, dout holds last result
    // RUN    | applying one pi round per clock
    // DONE   | dout is final for one cycle; start here restarts with no bubble
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [25*W-1:0]  state_q, state_d;
    logic [25*W-1:0]  fwd_s, inv_s;

    // Both maps are bijections, so every destination lane is driven exactly once.
    for (genvar gy = 0; gy < 5; gy++) begin : g_row
        for (genvar gx = 0; gx < 5; gx++) begin : g_col
            localparam int SRC = 5*gy + gx;
            localparam int FWD = 5*((2*gx + 3*gy + 2) % 5) + gy;
            localparam int INV = 5*gx + ((gx + 3*gy + 4) % 5);
            assign fwd_s[FWD*W +: W] = state_q[SRC*W +: W];
            assign inv_s[INV*W +: W] = state_q[SRC*W +: W];
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        state_d = state_q;
        case (fsm_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = din_i;
                    cnt_d   = rounds_i;
                    mode_d  = inv_i;
                    fsm_d   = (rounds_i == '0) ? S_DONE : S_RUN;
                end else if (fsm_q == S_DONE) begin
                    fsm_d = S_IDLE;
                end
            end
            S_RUN: begin
                state_d = mode_q ? inv_s : fwd_s;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    fsm_d = S_DONE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            state_q <= state_d;
        end
    end

    assign busy_o = (fsm_q == S_RUN);
    assign done_o = (fsm_q == S_DONE);
    assign dout_o = state_q;

endmodule

// File: tb/tb_pi_permute_engine.sv
// Directed bench for pi_permute_engine: W=8 and W=1 instances run in lockstep,
// results checked against a scoreboard filled when each job is launched.
module tb_pi_permute_engine;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         inv;
    logic [4:0]   rounds;
    logic [199:0] din8;
    logic [24:0]  din1;
    logic         busy8, done8, busy1, done1;
    logic [199:0] dout8;
    logic [24:0]  dout1;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int jobs_exp = 0;
    logic [199:0] sb_q[$];

    pi_permute_engine #(.W(8), .CNT_W(5)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .inv_i(inv),
        .rounds_i(rounds), .din_i(din8),
        .busy_o(busy8), .done_o(done8), .dout_o(dout8)
    );

    pi_permute_engine #(.W(1), .CNT_W(5)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .inv_i(inv),
        .rounds_i(rounds), .din_i(din1),
        .busy_o(busy1), .done_o(done1), .dout_o(dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // W=1 instance sees the LSB of each 8-bit lane.
    always_comb begin
        din1 = '0;
        for (int l = 0; l < 25; l++) din1[l] = din8[l*8];
    end

    function automatic logic [24:0] lsb25(input logic [199:0] s);
        logic [24:0] r;
        r = '0;
        for (int l = 0; l < 25; l++) r[l] = s[l*8];
        return r;
    endfunction

    function automatic logic [199:0] pi_fwd(input logic [199:0] s);
        logic [199:0] r;
        r = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[(5*((2*x + 3*y + 2) % 5) + y)*8 +: 8] = s[(5*y + x)*8 +: 8];
        return r;
    endfunction

    // Inverse taken as forward^23, since the forward map has order 24.
    function automatic logic [199:0] model(input logic [199:0] d, input logic m, input int n);
        logic [199:0] s;
        s = d;
        for (int i = 0; i < n; i++) begin
            if (m) for (int j = 0; j < 23; j++) s = pi_fwd(s);
            else s = pi_fwd(s);
        end
        return s;
    endfunction

    function automatic logic [199:0] rand200();
        logic [223:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) r = {r[191:0], $urandom()};
        return r[199:0];
    endfunction

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done8) begin
            n_done++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 200'd1, 200'd0);
            end else begin
                logic [199:0] e;
                e = sb_q.pop_front();
                chk("sb_dout8", dout8, e);
                chk("sb_dout1", {175'd0, dout1}, {175'd0, lsb25(e)});
                chk("sb_done1", {199'd0, done1}, 200'd1);
            end
        end
    end

    task automatic launch(input logic [199:0] d, input logic m, input int n);
        @(negedge clk);
        start  = 1'b1;
        din8   = d;
        inv    = m;
        rounds = n[4:0];
        sb_q.push_back(model(d, m, n));
        jobs_exp++;
    endtask

    // Called at the first negedge after the accepting edge.
    task automatic wait_done(input int exp_lat, input string tag, output logic [199:0] res);
        int k;
        int nb;
        k = 0;
        nb = 0;
        while (!done8 && k < 300) begin
            if (busy8) nb++;
            k++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, k, exp_lat);
        chk({tag, "_busy"}, nb, exp_lat);
        res = dout8;
    endtask

    task automatic job(input logic [199:0] d, input logic m, input int n, input string tag,
                       output logic [199:0] res);
        launch(d, m, n);
        @(negedge clk);
        start = 1'b0;
        wait_done(n, tag, res);
        @(negedge clk);
        chk({tag, "_done_drop"}, {199'd0, done8}, 200'd0);
    endtask

    initial begin
        logic [199:0] d, res, res2;
        logic [24:0]  v;

        rst_n  = 1'b0;
        start  = 1'b0;
        inv    = 1'b0;
        rounds = '0;
        din8   = '0;
        #12;
        chk("rst_state", {busy8, done8, dout8}, 202'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", {busy8, done8, dout8}, 202'd0);

        // single-lane moves, with a non-symmetric byte to expose intra-lane reordering
        job(200'hA5, 1'b0, 1, "lane0", res);
        chk("lane0_abs", res, 200'hA5 << 80);
        job(200'hA5 << 8, 1'b0, 1, "lane1", res);
        chk("lane1_abs", res, 200'hA5 << 160);
        job(200'hA5 << 96, 1'b0, 1, "lane12", res);
        chk("lane12_abs", res, 200'hA5 << 96);
        repeat (3) @(negedge clk);
        chk("hold_idle", dout8, 200'hA5 << 96);

        d = rand200();
        job(d, 1'b0, 24, "order24", res);
        chk("order24_abs", res, d);
        job(d, 1'b0, 5, "fwd5", res);
        job(res, 1'b1, 5, "inv5", res2);
        chk("inv_restore", res2, d);

        v = 25'h1ABCDEF;
        d = rand200();
        for (int l = 0; l < 25; l++) d[l*8] = v[l];
        job(d, 1'b1, 0, "r0", res);
        chk("r0_dout1", {175'd0, dout1}, {175'd0, v});

        job(rand200(), 1'b0, 31, "max31", res);

        // inputs churned during RUN must be ignored
        d = rand200();
        launch(d, 1'b0, 10);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start  = 1'b1;
            din8   = rand200();
            inv    = 1'b1;
            rounds = 5'd3;
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(5, "ignore", res);
        chk("ignore_abs", res, model(d, 1'b0, 10));

        // back-to-back with start held through DONE
        launch(rand200(), 1'b0, 3);
        @(negedge clk);
        d = rand200();
        din8   = d;
        inv    = 1'b1;
        rounds = 5'd4;
        sb_q.push_back(model(d, 1'b1, 4));
        jobs_exp++;
        wait_done(3, "b2b_a", res);
        @(negedge clk);
        chk("b2b_nobubble", {198'd0, busy8, done8}, 200'd2);
        start = 1'b0;
        wait_done(4, "b2b_b", res);

        // reset mid-run aborts without a done pulse
        launch(rand200(), 1'b0, 20);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", {199'd0, busy8}, 200'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outs8", {busy8, done8, dout8}, 202'd0);
        chk("abort_outs1", {175'd0, busy1, done1, dout1}, 202'd0);
        sb_q.delete();
        jobs_exp--;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_abort", {busy8, done8, dout8}, 202'd0);

        chk("done_count", n_done, jobs_exp);
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
